// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared hart fetch definitions: default widths, fetch entry
// and memory-controller request/response records.
package fetch_prefetch_queue_pkg;

   localparam int HART_DATA_WIDTH    = 32;
   localparam int HART_ADDRESS_WIDTH = 32;
   localparam int INSTRUCTION_BYTES  = 4;

   typedef struct packed {
      logic [HART_DATA_WIDTH-1:0]    instruction;
      logic [HART_ADDRESS_WIDTH-1:0] address;
      logic                          error;
   } fetch_entry_t;

   typedef struct packed {
      logic                          valid;
      logic [HART_ADDRESS_WIDTH-1:0] address;
      logic                          write;
      logic [HART_DATA_WIDTH-1:0]    write_data;
   } mc_request_t;

   typedef struct packed {
      logic                       valid;
      logic [HART_DATA_WIDTH-1:0] read_data;
      logic                       error;
   } mc_response_t;

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with power-of-two pointer wrap;
// used for the instruction buffer and the in-flight PC tags.
module fetch_fifo
   import fetch_prefetch_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                   clock,
   input  logic                   clear,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       push_data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       head_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [PW-1:0] MASK = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_q, rd_d;
   logic [PW-1:0]    wr_q, wr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_q];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      rd_d    = rd_q;
      wr_d    = wr_q;
      count_d = count_q;
      if (flush_i) begin
         rd_d    = '0;
         wr_d    = '0;
         count_d = '0;
      end else begin
         if (do_pop)
            rd_d = (rd_q + PW'(1)) & MASK;
         if (do_push)
            wr_d = (wr_q + PW'(1)) & MASK;
         if (do_push & ~do_pop)
            count_d = count_q + CW'(1);
         else if (do_pop & ~do_push)
            count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push & ~flush_i)
         mem_q[wr_q] <= push_data_i;
   end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Pipelined hart fetch: sequential prefetch with credit-based
// buffering, redirect flush and fault halt.
module fetch_prefetch_queue
   import fetch_prefetch_queue_pkg::*;
#(
   parameter int DATA_WIDTH      = HART_DATA_WIDTH,
   parameter int ADDRESS_WIDTH   = HART_ADDRESS_WIDTH,
   parameter int DEPTH           = 4,
   parameter int MAX_OUTSTANDING = 2,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                     clock,
   input  logic                     clear,
   input  logic                     should_fetch,
   input  logic                     redirect_valid,
   input  logic [ADDRESS_WIDTH-1:0] redirect_address,
   output logic                     hart_to_memory_controller_valid,
   input  logic                     hart_to_memory_controller_ready,
   output logic [ADDRESS_WIDTH-1:0] hart_to_memory_controller_address,
   output logic                     hart_to_memory_controller_write,
   output logic [DATA_WIDTH-1:0]    hart_to_memory_controller_write_data,
   input  logic                     memory_controller_to_hart_valid,
   input  logic [DATA_WIDTH-1:0]    memory_controller_to_hart_read_data,
   input  logic                     memory_controller_to_hart_error,
   output logic                     memory_controller_to_hart_ready,
   output logic                     instruction_valid,
   input  logic                     instruction_ready,
   output logic [DATA_WIDTH-1:0]    instruction,
   output logic [ADDRESS_WIDTH-1:0] instruction_address,
   output logic                     instruction_error,
   output logic                     faulted
);

   localparam int TAG_DEPTH = 1 << $clog2(MAX_OUTSTANDING);
   localparam int EW = DATA_WIDTH + ADDRESS_WIDTH + 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int IW = $clog2(TAG_DEPTH) + 1;
   localparam int SW = ((CW > IW) ? CW : IW) + 1;

   logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
   logic [IW-1:0]            discard_q, discard_d;
   logic                     faulted_q, faulted_d;

   logic [IW-1:0]            in_flight, in_flight_next;
   logic [CW-1:0]            fifo_count;
   logic                     fifo_full, fifo_empty;
   logic                     tag_full, tag_empty;
   logic [ADDRESS_WIDTH-1:0] resp_pc;
   logic [EW-1:0]            head;
   logic [SW-1:0]            occupancy;
   logic                     issue_ok, fire, resp, accept, pop;

   // Buffer space is reserved at issue, so a response can always be stored.
   assign occupancy = SW'(fifo_count) + SW'(in_flight);
   assign issue_ok  = should_fetch & ~faulted_q & ~redirect_valid
                    & ~tag_full & ~fifo_full
                    & (SW'(in_flight) < SW'(MAX_OUTSTANDING))
                    & (occupancy < SW'(DEPTH));
   assign fire   = issue_ok & hart_to_memory_controller_ready;
   assign resp   = memory_controller_to_hart_valid & ~tag_empty;
   assign accept = resp & ~redirect_valid & (discard_q == '0);
   assign pop    = instruction_valid & instruction_ready & ~redirect_valid;

   assign in_flight_next = in_flight + IW'(fire) - IW'(resp);

   fetch_fifo #(
      .DEPTH(TAG_DEPTH),
      .WIDTH(ADDRESS_WIDTH)
   ) u_tags (
      .clock      (clock),
      .clear      (clear),
      .flush_i    (1'b0),
      .push_i     (fire),
      .push_data_i(pc_q),
      .pop_i      (resp),
      .head_o     (resp_pc),
      .full_o     (tag_full),
      .empty_o    (tag_empty),
      .count_o    (in_flight)
   );

   fetch_fifo #(
      .DEPTH(DEPTH),
      .WIDTH(EW)
   ) u_buffer (
      .clock      (clock),
      .clear      (clear),
      .flush_i    (redirect_valid),
      .push_i     (accept),
      .push_data_i({memory_controller_to_hart_read_data, resp_pc,
                    memory_controller_to_hart_error}),
      .pop_i      (pop),
      .head_o     (head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count)
   );

   always_comb begin
      pc_d      = pc_q;
      discard_d = discard_q;
      faulted_d = faulted_q;
      if (redirect_valid) begin
         pc_d      = redirect_address & ~ADDRESS_WIDTH'(INSTRUCTION_BYTES - 1);
         faulted_d = 1'b0;
         discard_d = in_flight_next;
      end else begin
         if (fire)
            pc_d = pc_q + ADDRESS_WIDTH'(INSTRUCTION_BYTES);
         // Everything still outstanding after a fault is younger: drop it.
         if (accept & memory_controller_to_hart_error) begin
            faulted_d = 1'b1;
            discard_d = in_flight_next;
         end else if (resp & (discard_q != '0)) begin
            discard_d = discard_q - IW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         pc_q      <= RESET_PC;
         discard_q <= '0;
         faulted_q <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         discard_q <= discard_d;
         faulted_q <= faulted_d;
      end
   end

   assign hart_to_memory_controller_valid      = issue_ok;
   assign hart_to_memory_controller_address    = issue_ok ? pc_q : '0;
   assign hart_to_memory_controller_write      = 1'b0;
   assign hart_to_memory_controller_write_data = '0;
   assign memory_controller_to_hart_ready      = 1'b1;

   assign instruction_valid   = ~fifo_empty;
   assign instruction         = instruction_valid ? head[EW-1 -: DATA_WIDTH] : '0;
   assign instruction_address = instruction_valid ? head[ADDRESS_WIDTH:1] : '0;
   assign instruction_error   = instruction_valid & head[0];
   assign faulted             = faulted_q;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomized bench for fetch_prefetch_queue against a queue-based
// model of outstanding fetches and buffered instructions.
module tb_fetch_prefetch_queue;

   localparam int MAXO  = 2;
   localparam int DEPTH = 4;
   localparam logic [31:0] RPC = 32'h100;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        clear, should_fetch, redirect_valid;
   logic [31:0] redirect_address;
   logic        hv, hr, hw, mv, me, mr, iv, ir, ie, flt;
   logic [31:0] ha, hwd, md, ins, ia;

   fetch_prefetch_queue #(
      .DEPTH(DEPTH),
      .MAX_OUTSTANDING(MAXO),
      .RESET_PC(RPC)
   ) dut (
      .clock(clock),
      .clear(clear),
      .should_fetch(should_fetch),
      .redirect_valid(redirect_valid),
      .redirect_address(redirect_address),
      .hart_to_memory_controller_valid(hv),
      .hart_to_memory_controller_ready(hr),
      .hart_to_memory_controller_address(ha),
      .hart_to_memory_controller_write(hw),
      .hart_to_memory_controller_write_data(hwd),
      .memory_controller_to_hart_valid(mv),
      .memory_controller_to_hart_read_data(md),
      .memory_controller_to_hart_error(me),
      .memory_controller_to_hart_ready(mr),
      .instruction_valid(iv),
      .instruction_ready(ir),
      .instruction(ins),
      .instruction_address(ia),
      .instruction_error(ie),
      .faulted(flt)
   );

   typedef struct { logic [31:0] addr; bit drop; } flight_t;
   typedef struct { logic [31:0] data; logic [31:0] addr; bit err; } entry_t;

   flight_t     m_fl[$];
   entry_t      m_fifo[$];
   logic [31:0] m_pc = RPC;
   bit          m_flt = 1'b0;
   bit          m_fire = 1'b0;
   bit          m_pop = 1'b0;
   flight_t     m_r;
   bit          m_have_r;

   logic [31:0] mc_pend[$];
   bit          d_fire = 1'b0;
   logic [31:0] d_addr;

   int tests = 0;
   int fails = 0;
   int p_fetch, p_ready, p_resp, p_pop, p_err;
   bit err_en;
   logic [31:0] err_addr;

   logic [31:0] issued[$];
   entry_t      delivered[$];

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      int  n;
      bit  ev;
      n  = m_fifo.size();
      ev = should_fetch && !m_flt && !redirect_valid
         && (m_fl.size() < MAXO) && (n + m_fl.size() < DEPTH);
      check("req_valid", 64'(hv), 64'(ev));
      check("req_addr", 64'(ha), ev ? 64'(m_pc) : 64'd0);
      check("req_write", 64'(hw), 64'd0);
      check("req_wdata", 64'(hwd), 64'd0);
      check("resp_ready", 64'(mr), 64'd1);
      check("instr_valid", 64'(iv), 64'(n > 0));
      check("instr", 64'(ins), n > 0 ? 64'(m_fifo[0].data) : 64'd0);
      check("instr_addr", 64'(ia), n > 0 ? 64'(m_fifo[0].addr) : 64'd0);
      check("instr_err", 64'(ie), n > 0 ? 64'(m_fifo[0].err) : 64'd0);
      check("faulted", 64'(flt), 64'(m_flt));
      m_fire = ev && hr;
      m_pop  = (n > 0) && ir;
      d_fire = hv && hr;
      d_addr = ha;
      if (!clear && hv && hr)
         issued.push_back(ha);
      if (!clear && !redirect_valid && iv && ir)
         delivered.push_back('{ins, ia, ie});
   endtask

   task automatic step(input bit clr, input bit rd, input logic [31:0] ra);
      @(negedge clock);
      should_fetch = ($urandom_range(99) < p_fetch);
      hr = ($urandom_range(99) < p_ready);
      ir = ($urandom_range(99) < p_pop);
      if (mc_pend.size() > 0 && $urandom_range(99) < p_resp) begin
         mv = 1'b1;
         md = word_of(mc_pend[0]);
         me = (err_en && mc_pend[0] == err_addr) || ($urandom_range(99) < p_err);
      end else begin
         mv = 1'b0;
         md = $urandom;
         me = 1'($urandom);
      end
      clear = clr;
      redirect_valid = rd;
      redirect_address = ra;
      #1;
      compare();
   endtask

   always @(posedge clock) begin
      if (clear) begin
         m_pc = RPC;
         m_fl.delete();
         m_fifo.delete();
         m_flt = 1'b0;
         mc_pend.delete();
      end else begin
         if (mv && mc_pend.size() > 0)
            void'(mc_pend.pop_front());
         if (d_fire)
            mc_pend.push_back(d_addr);
         m_have_r = 1'b0;
         if (mv && m_fl.size() > 0) begin
            m_r = m_fl.pop_front();
            m_have_r = 1'b1;
         end
         if (m_fire)
            m_fl.push_back('{m_pc, 1'b0});
         if (redirect_valid) begin
            m_fifo.delete();
            foreach (m_fl[i]) m_fl[i].drop = 1'b1;
            m_pc = redirect_address & ~32'h3;
            m_flt = 1'b0;
         end else begin
            if (m_pop)
               void'(m_fifo.pop_front());
            if (m_have_r && !m_r.drop) begin
               m_fifo.push_back('{md, m_r.addr, me});
               if (me) begin
                  m_flt = 1'b1;
                  foreach (m_fl[i]) m_fl[i].drop = 1'b1;
               end
            end
            if (m_fire)
               m_pc = m_pc + 32'd4;
         end
      end
   end

   task automatic knobs(input int f, input int r, input int s,
                        input int p, input int e);
      p_fetch = f; p_ready = r; p_resp = s; p_pop = p; p_err = e;
   endtask

   initial begin
      clear = 1'b1; should_fetch = 1'b0; redirect_valid = 1'b0;
      redirect_address = '0; hr = 1'b0; mv = 1'b0; md = '0; me = 1'b0;
      ir = 1'b0; err_en = 1'b0; err_addr = '0;
      knobs(0, 100, 100, 100, 0);
      step(1, 0, 0);
      step(0, 0, 0);
      check("rst_req_valid", 64'(hv), 64'd0);
      check("rst_req_addr", 64'(ha), 64'd0);
      check("rst_instr_valid", 64'(iv), 64'd0);
      check("rst_resp_ready", 64'(mr), 64'd1);

      // streaming
      knobs(100, 100, 100, 100, 0);
      issued.delete(); delivered.delete();
      repeat (20) step(0, 0, 0);
      check("stream_issued", 64'(issued.size()), 64'd20);
      check("stream_a0", issued.size() > 2 ? 64'(issued[0]) : 64'hx, 64'h100);
      check("stream_a1", issued.size() > 2 ? 64'(issued[1]) : 64'hx, 64'h104);
      check("stream_a2", issued.size() > 2 ? 64'(issued[2]) : 64'hx, 64'h108);
      check("stream_d0", delivered.size() > 0 ? 64'(delivered[0].addr) : 64'hx, 64'h100);
      check("stream_w0", delivered.size() > 0 ? 64'(delivered[0].data) : 64'hx,
            64'(word_of(32'h100)));

      // backpressure then release
      knobs(100, 100, 100, 0, 0);
      repeat (12) step(0, 0, 0);
      check("bp_stall", 64'(hv), 64'd0);
      check("bp_held", 64'(iv), 64'd1);
      knobs(100, 100, 100, 100, 0);
      repeat (20) step(0, 0, 0);
      for (int i = 1; i < delivered.size(); i++)
         check("seq_step", 64'(delivered[i].addr), 64'(delivered[i-1].addr + 32'd4));

      // redirect with two in flight
      knobs(100, 100, 0, 100, 0);
      for (int k = 0; k < 10 && m_fl.size() != MAXO; k++) step(0, 0, 0);
      check("rd_stall", 64'(hv), 64'd0);
      knobs(100, 100, 100, 100, 0);
      step(0, 1, 32'h2003);
      issued.delete(); delivered.delete();
      step(0, 0, 0);
      check("rd_empty", 64'(iv), 64'd0);
      repeat (10) step(0, 0, 0);
      check("rd_a0", issued.size() > 0 ? 64'(issued[0]) : 64'hx, 64'h2000);
      check("rd_d0", delivered.size() > 0 ? 64'(delivered[0].addr) : 64'hx, 64'h2000);

      // clear mid-stream
      step(1, 0, 0);
      knobs(0, 100, 100, 100, 0);
      step(0, 0, 0);
      check("clr_req_valid", 64'(hv), 64'd0);
      check("clr_instr_valid", 64'(iv), 64'd0);
      check("clr_resp_ready", 64'(mr), 64'd1);

      // error on 0x108
      knobs(100, 100, 100, 100, 0);
      err_en = 1'b1; err_addr = 32'h108;
      issued.delete(); delivered.delete();
      repeat (15) step(0, 0, 0);
      check("err_first", issued.size() > 0 ? 64'(issued[0]) : 64'hx, 64'h100);
      check("err_issued", 64'(issued.size()), 64'd4);
      check("err_delivered", 64'(delivered.size()), 64'd3);
      check("err_addr", delivered.size() > 2 ? 64'(delivered[2].addr) : 64'hx, 64'h108);
      check("err_flag", delivered.size() > 2 ? 64'(delivered[2].err) : 64'hx, 64'd1);
      check("err_prev", delivered.size() > 2 ? 64'(delivered[1].err) : 64'hx, 64'd0);
      check("err_faulted", 64'(flt), 64'd1);
      check("err_halt", 64'(hv), 64'd0);
      err_en = 1'b0;
      step(0, 1, 32'h300);
      issued.delete();
      step(0, 0, 0);
      check("unfault", 64'(flt), 64'd0);
      repeat (5) step(0, 0, 0);
      check("unfault_a0", issued.size() > 0 ? 64'(issued[0]) : 64'hx, 64'h300);

      // wrap
      step(0, 1, 32'hFFFF_FFFC);
      issued.delete(); delivered.delete();
      repeat (6) step(0, 0, 0);
      check("wrap_a0", issued.size() > 1 ? 64'(issued[0]) : 64'hx, 64'hFFFF_FFFC);
      check("wrap_a1", issued.size() > 1 ? 64'(issued[1]) : 64'hx, 64'h0);
      check("wrap_d1", delivered.size() > 1 ? 64'(delivered[1].addr) : 64'hx, 64'h0);

      // randomized traffic
      for (int blk = 0; blk < 30; blk++) begin
         knobs($urandom_range(100, 30), $urandom_range(100, 20),
               $urandom_range(100, 20), $urandom_range(100, 10),
               $urandom_range(5, 0));
         repeat (100)
            step($urandom_range(199) == 0, $urandom_range(49) == 0, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
